// File: rtl/instr_mem_pkg.sv
// Shared definitions for the fetch-stage instruction memory.
//   NOP_INSTR_DEFAULT : word returned on a faulting fetch (addi x0,x0,0)
//   FAULT_MISALIGNED  : fault vector bit for a non word-aligned address
//   FAULT_RANGE       : fault vector bit for an address beyond the array
//   fault_t           : two-bit fault vector carried with each response
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam int          FAULT_MISALIGNED  = 0;
  localparam int          FAULT_RANGE       = 1;

  typedef logic [1:0] fault_t;

  // Pack the two fault conditions into a fault vector.
  function automatic fault_t fault_encode(input logic misaligned, input logic out_of_range);
    fault_t f;
    f                   = 2'b00;
    f[FAULT_MISALIGNED] = misaligned;
    f[FAULT_RANGE]      = out_of_range;
    return f;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_WIDTH instruction storage.
//   clk     : clock
//   wr_en   : write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr : word index to write
//   wr_data : word to write
//   rd_en   : read enable, rd_data updated from rd_addr on the rising edge
//   rd_addr : word index to read
//   rd_data : registered read data, holds while rd_en is low
// The array and the read register are deliberately not reset so that the
// program image survives a core reset.
module imem_array #(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Synchronous write port and registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// Fetch-stage instruction memory with a 1-cycle registered read behind a
// valid/ready request/response handshake.
//   clk, reset          : clock, asynchronous active-high reset
//   req_valid/req_ready : fetch request handshake, req_addr is a byte address
//   rsp_valid/rsp_ready : response handshake
//   rsp_instr/rsp_addr  : fetched word and the byte address it belongs to
//   rsp_fault           : bit0 misaligned, bit1 out-of-range (NOP returned)
//   flush               : drop the held response, block requests this cycle
//   ld_en/ld_addr/ld_data : program-load write port, blocks requests
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter int ADDR_WIDTH                = 32,
  parameter int DATA_WIDTH                = 32,
  parameter int DEPTH                     = 256,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(NOP_INSTR_DEFAULT),
  localparam int IDX_W                    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [1:0]            rsp_fault,
  input  logic                  flush,
  input  logic                  ld_en,
  input  logic [IDX_W-1:0]      ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
);

  logic                  accept_s;
  logic                  misaligned_s;
  logic                  out_of_range_s;
  logic                  rd_en_s;
  logic [ADDR_WIDTH-1:0] upper_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q,  rsp_addr_d;
  fault_t                rsp_fault_q, rsp_fault_d;
  // Set when the response word comes from the array rather than NOP_INSTR.
  logic                  from_mem_q,  from_mem_d;

  // Request side: handshake and fault decode.
  always_comb begin
    req_ready      = !reset && !flush && !ld_en && (!rsp_valid_q || rsp_ready);
    accept_s       = req_valid && req_ready;
    misaligned_s   = (req_addr[1:0] != 2'b00);
    // Any bit above the word index means the address is past the array.
    upper_s        = req_addr >> (IDX_W + 2);
    out_of_range_s = (upper_s != {ADDR_WIDTH{1'b0}});
    rd_idx_s       = req_addr[IDX_W+1:2];
    // Faulting fetches never touch the array.
    rd_en_s        = accept_s && !misaligned_s && !out_of_range_s;
  end

  imem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (rd_en_s),
    .rd_addr (rd_idx_s),
    .rd_data (rd_data_s)
  );

  // Next-state of the response register.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_fault_d = rsp_fault_q;
    from_mem_d  = from_mem_q;
    if (flush) begin
      // Flush wins over drain; no accept can coincide with it.
      rsp_valid_d = 1'b0;
    end else if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_addr_d  = req_addr;
      rsp_fault_d = fault_encode(misaligned_s, out_of_range_s);
      from_mem_d  = rd_en_s;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= {ADDR_WIDTH{1'b0}};
      rsp_fault_q <= 2'b00;
      from_mem_q  <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_fault_q <= rsp_fault_d;
      from_mem_q  <= from_mem_d;
    end
  end

  // The read data is already registered in the array; only the NOP
  // substitution is selected here, by a registered flag.
  always_comb begin
    rsp_valid = rsp_valid_q;
    rsp_addr  = rsp_addr_q;
    rsp_fault = rsp_fault_q;
    if (from_mem_q) begin
      rsp_instr = rd_data_s;
    end else begin
      rsp_instr = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
module tb_instr_mem_fetch;

  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;
  logic        flush;
  logic        ld_en;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;

  instr_mem_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  bit          busy;
  bit          in_reset;
  int          errors;
  int          checks;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: fault and data purely from the address rules.
  function automatic rsp_t predict(input logic [31:0] a);
    rsp_t r;
    logic mis, oor;
    mis     = (a % 4) != 0;
    oor     = (a / 4) >= DEPTH;
    r.addr  = a;
    r.fault = {oor, mis};
    r.instr = (mis || oor) ? NOP : ref_mem[(a / 4) % DEPTH];
    return r;
  endfunction

  // One clock of stimulus: drive at negedge, predict at +2, edge at +5.
  task automatic cycle(input logic rv, input logic [31:0] a, input logic rr,
                       input logic fl, input logic ld, input logic [7:0] la,
                       input logic [31:0] ldd);
    bit exp_ready, acc;
    @(negedge clk);
    req_valid = rv; req_addr = a; rsp_ready = rr;
    flush = fl; ld_en = ld; ld_addr = la; ld_data = ldd;
    #2;
    exp_ready = !fl && !ld && (!busy || rr);
    acc       = rv && exp_ready;
    chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    if (acc) exp_q.push_back(predict(a));
    if (ld) ref_mem[la] = ldd;
    if (fl)            busy = 1'b0;
    else if (acc)      busy = 1'b1;
    else if (busy && rr) busy = 1'b0;
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 32'd0, rr, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] a, input logic rr);
    cycle(1'b1, a, rr, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic load(input logic [7:0] la, input logic [31:0] d);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, la, d);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    bit          prev_stall;
    logic [31:0] p_instr, p_addr;
    logic [1:0]  p_fault;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (in_reset) begin
        prev_stall = 1'b0;
      end else begin
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_q.size() != 0});
        if (prev_stall) begin
          chk("stall_instr", rsp_instr, p_instr);
          chk("stall_addr", rsp_addr, p_addr);
          chk("stall_fault", {30'd0, rsp_fault}, {30'd0, p_fault});
        end
        if (exp_q.size() != 0) begin
          if (flush) begin
            void'(exp_q.pop_front());
          end else if (rsp_ready && rsp_valid) begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_instr", rsp_instr, e.instr);
            chk("rsp_addr", rsp_addr, e.addr);
            chk("rsp_fault", {30'd0, rsp_fault}, {30'd0, e.fault});
          end
        end
        prev_stall = rsp_valid && !rsp_ready && !flush;
        p_instr = rsp_instr; p_addr = rsp_addr; p_fault = rsp_fault;
      end
    end
  end

  initial begin
    errors = 0; checks = 0; busy = 1'b0; in_reset = 1'b1;
    req_valid = 1'b0; req_addr = 32'd0; rsp_ready = 1'b0; flush = 1'b0;
    ld_en = 1'b0; ld_addr = 8'd0; ld_data = 32'd0;
    reset = 1'b1;
    #3;
    chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_instr", rsp_instr, NOP);
    chk("reset_addr", rsp_addr, 32'd0);
    chk("reset_fault", {30'd0, rsp_fault}, 32'd0);
    chk("reset_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); #3;
    reset = 1'b0; in_reset = 1'b0;

    // Program image.
    for (int i = 0; i < DEPTH; i++) load(i[7:0], $urandom);
    load(8'd0, 32'h00A0_0093);
    load(8'd1, 32'h0140_0113);

    // Back-to-back fetches.
    fetch(32'h0, 1'b1);
    fetch(32'h4, 1'b1);
    idle(1'b1);

    // Stall then drain.
    fetch(32'h8, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Faults.
    fetch(32'h6, 1'b1);
    fetch(32'h400, 1'b1);
    fetch(32'h402, 1'b1);
    idle(1'b1);

    // Flush with a held response; request in the flush cycle is refused.
    fetch(32'h10, 1'b0);
    cycle(1'b1, 32'h14, 1'b0, 1'b1, 1'b0, 8'd0, 32'd0);
    idle(1'b0);

    // Write then immediate read.
    load(8'd3, 32'hDEAD_BEEF);
    fetch(32'hC, 1'b1);
    idle(1'b1);

    // Flush and load together.
    fetch(32'h20, 1'b0);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 8'd5, 32'h1234_5678);
    fetch(32'h14, 1'b1);
    idle(1'b1);

    // Asynchronous reset with a response pending.
    fetch(32'h4, 1'b0);
    idle(1'b0);
    #1;
    reset = 1'b1; in_reset = 1'b1;
    #1;
    chk("async_reset_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_reset_ready", {31'd0, req_ready}, 32'd0);
    exp_q.delete();
    busy = 1'b0;
    @(negedge clk); #3;
    reset = 1'b0; in_reset = 1'b0;
    idle(1'b1);
    fetch(32'h0, 1'b1);
    idle(1'b1);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int kind;
      kind = $urandom_range(0, 7);
      a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      if (kind == 6) a = a | 32'($urandom_range(1, 3));
      if (kind == 7) a = a | (32'($urandom_range(1, 1023)) << 10);
      cycle(($urandom % 4) != 0, a, ($urandom % 3) != 0, ($urandom % 12) == 0,
            ($urandom % 8) == 0, 8'($urandom), $urandom);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
    idle(1'b1);
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
